dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//   Store buffer between the single-cycle core's data port and an external data
//   memory with a slow, handshaked write channel. Core stores are queued and
//   drained in program order. Loads are served combinationally: from the youngest
//   matching queued store, else from the memory's asynchronous read port.
//   Stall output holds the core's PC when a store arrives at a full queue.
// PARAMETERS
//   DEPTH  4  number of queued stores; power of two, >= 2
//   AW     8  address width (core ALU result width)
//   DW     8  data width (core store-data width)
// PORTS
//   clk          in   1    system clock, rising edge
//   reset_n      in   1    asynchronous, active-low reset
//   cpu_memwrite in   1    core store strobe, this cycle
//   cpu_addr     in   AW   core load/store address
//   cpu_wdata    in   DW   core store data
//   cpu_rdata    out  16   load data to core, {(16-DW)'b0, data}
//   stall        out  1    core must hold PC and re-present the store
//   mem_raddr    out  AW   external async read address (= cpu_addr)
//   mem_rdata    in   DW   external async read data
//   mem_wvalid   out  1    head entry valid on write channel
//   mem_waddr    out  AW   head entry address
//   mem_wdata    out  DW   head entry data
//   mem_wready   in   1    memory accepts head entry this cycle
//   sb_count     out  log2(DEPTH)+1  queued entries
// BEHAVIOUR
//   - Reset (reset_n=0, async): head=tail=0, count=0; mem_wvalid=0, stall=0,
//     sb_count=0. Queued stores are discarded, including a drain in flight.
//   - State is a circular FIFO: head/tail pointers wrap mod DEPTH, registered count.
//   - full = (count==DEPTH), empty = (count==0), both from registered count.
//   - stall = cpu_memwrite & full. Combinational. No path from mem_wready.
//   - Enqueue at posedge when cpu_memwrite & !full: entry[tail]<={addr,wdata};
//     tail++. Latency to mem_wvalid: 1 cycle.
//   - Drain: mem_wvalid=!empty; mem_waddr/mem_wdata=entry[head]. Transfer on
//     mem_wvalid & mem_wready at posedge: head++. Outputs stay stable until the
//     transfer; mem_wvalid never drops without a transfer (except reset).
//   - Simultaneous enqueue+transfer: count unchanged, both pointers advance.
//     When full: stall stays asserted that cycle even if mem_wready=1; no enqueue.
//   - count: +1 on enqueue only, -1 on transfer only, else unchanged.
//     Overflow and underflow are impossible by construction.
//   - Load path is combinational, every cycle, regardless of cpu_memwrite:
//     scan valid entries youngest (tail-1) to oldest (head); the first with
//     addr==cpu_addr supplies data. On a miss, data = mem_rdata.
//   - The entry being transferred this cycle is still a forwarding source
//     (it is removed at the edge).
//   - No write merging: repeated stores to one address each occupy an entry and
//     each drain in order.
//   - mem_raddr = cpu_addr, always.
// TESTING
//   - Reset: assert reset_n=0 mid-drain with count=3 -> mem_wvalid=0 immediately;
//     sb_count=0 after release.
//   - Single store: addr 0x10 data 0xA5, mem_wready=1 -> next cycle
//     mem_wvalid=1, waddr=0x10, wdata=0xA5; count back to 0 after 1 cycle.
//   - Fill: mem_wready=0, 5 stores to 0x01..0x05 -> stall=1 on the 5th;
//     sb_count=4; raise mem_wready -> 0x01..0x04 drain in order; the 5th is
//     accepted only after the stall drops.
//   - Forwarding: store 0x20<=0x11 then 0x20<=0x22 (held); load 0x20 ->
//     cpu_rdata=0x0022. Load 0x21 with mem_rdata=0x7E -> 0x007E.
//   - Simultaneous: count=2, store + mem_wready=1 same cycle -> count stays 2,
//     order preserved.
//   - Wrap: 10 stores with random mem_wready -> memory receives all 10, in
//     order, none lost or duplicated.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// Core data-port and external write-channel signals seen by the store buffer.
// The master view belongs to the buffer; the slave view to the core/memory side.
interface dmem_store_buffer_if #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 3
);
   logic          cpu_memwrite;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [15:0]   cpu_rdata;
   logic          stall;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          mem_wvalid;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wready;
   logic [CW-1:0] sb_count;

   modport master (
      input  cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata, mem_wready,
      output cpu_rdata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, sb_count
   );

   modport slave (
      output cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata, mem_wready,
      input  cpu_rdata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, sb_count
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store queue with combinational youngest-match load forwarding
// between a single-cycle core and a handshaked external write channel.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input logic                clk,
   input logic                reset_n,
   dmem_store_buffer_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg, count_next;

   logic full, empty, enq, deq;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign enq   = bus.cpu_memwrite & ~full;
   assign deq   = ~empty & bus.mem_wready;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (enq) tail_next = tail_reg + PW'(1);
      if (deq) head_next = head_reg + PW'(1);
      case ({enq, deq})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Entry contents need no reset: count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[tail_reg] <= bus.cpu_addr;
         data_mem[tail_reg] <= bus.cpu_wdata;
      end
   end

   // Age 0 is the youngest entry (tail-1); age count-1 is the head.
   logic [PW-1:0]    age_idx [DEPTH];
   logic [DEPTH-1:0] hit;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
         assign age_idx[gi] = tail_reg - PW'(gi + 1);
         assign hit[gi]     = (CW'(gi) < count_reg) && (addr_mem[age_idx[gi]] == bus.cpu_addr);
      end
   endgenerate

   logic [DW-1:0] fwd_data;

   // Walk oldest to youngest so the youngest hit is the last to win.
   always_comb begin
      fwd_data = bus.mem_rdata;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hit[i]) fwd_data = data_mem[age_idx[i]];
      end
   end

   assign bus.cpu_rdata  = 16'(fwd_data);
   assign bus.stall      = bus.cpu_memwrite & full;
   assign bus.mem_raddr  = bus.cpu_addr;
   assign bus.mem_wvalid = ~empty;
   assign bus.mem_waddr  = addr_mem[head_reg];
   assign bus.mem_wdata  = data_mem[head_reg];
   assign bus.sb_count   = count_reg;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: reset, single store, fill/stall,
// forwarding, simultaneous enqueue+drain and pointer wrap.
module tb_dmem_store_buffer;
   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   dmem_store_buffer_if #(.AW(8), .DW(8), .CW(3)) bus ();

   dmem_store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] log_q [$];
   int log_rd = 0;

   // Capture transfers mid-cycle, when the handshake seen by the next edge is stable.
   always @(negedge clk) begin
      if (reset_n && bus.mem_wvalid && bus.mem_wready)
         log_q.push_back({bus.mem_waddr, bus.mem_wdata});
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_log(input string tag, input logic [15:0] exp);
      if (log_rd < log_q.size()) check_value(tag, 32'(log_q[log_rd]), 32'(exp));
      else check_value({tag, "_missing"}, log_q.size(), log_rd + 1);
      log_rd++;
   endtask

   task automatic store(input logic [7:0] a, input logic [7:0] d, input logic rdy);
      bus.cpu_memwrite = 1'b1;
      bus.cpu_addr     = a;
      bus.cpu_wdata    = d;
      bus.mem_wready   = rdy;
      step();
      bus.cpu_memwrite = 1'b0;
   endtask

   task automatic drain(input string tag);
      bus.cpu_memwrite = 1'b0;
      bus.mem_wready   = 1'b1;
      for (int c = 0; c < 50 && bus.sb_count != 0; c++) step();
      check_value(tag, 32'(bus.sb_count), 32'd0);
   endtask

   logic [15:0] rdy_pat = 16'b1011_0010_0110_1001;

   initial begin
      reset_n          = 1'b0;
      bus.cpu_memwrite = 1'b0;
      bus.cpu_addr     = '0;
      bus.cpu_wdata    = '0;
      bus.mem_rdata    = '0;
      bus.mem_wready   = 1'b0;
      #12;
      check_value("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
      check_value("rst_count",  32'(bus.sb_count),   32'd0);
      check_value("rst_stall",  32'(bus.stall),      32'd0);
      step();
      reset_n = 1'b1;
      step();

      // Single store with memory ready
      store(8'h10, 8'hA5, 1'b1);
      #1;
      check_value("single_wvalid", 32'(bus.mem_wvalid), 32'd1);
      check_value("single_waddr",  32'(bus.mem_waddr),  32'h10);
      check_value("single_wdata",  32'(bus.mem_wdata),  32'hA5);
      check_value("single_count1", 32'(bus.sb_count),   32'd1);
      step();
      check_value("single_count0", 32'(bus.sb_count),   32'd0);
      expect_log("single_log", 16'h10A5);

      // Fill with memory held off, 5th store stalls
      for (int k = 1; k <= 5; k++) begin
         bus.cpu_memwrite = 1'b1;
         bus.cpu_addr     = 8'(k);
         bus.cpu_wdata    = 8'(8'h30 + k);
         bus.mem_wready   = 1'b0;
         #1;
         check_value($sformatf("fill_stall%0d", k), 32'(bus.stall), 32'(k == 5));
         if (k < 5) step();
      end
      check_value("fill_count", 32'(bus.sb_count), 32'd4);
      bus.mem_wready = 1'b1;
      #1;
      check_value("full_stall_wready", 32'(bus.stall), 32'd1);
      step();
      check_value("after_xfer_count", 32'(bus.sb_count), 32'd3);
      check_value("stall_dropped",    32'(bus.stall),    32'd0);
      step();
      check_value("enq5_count", 32'(bus.sb_count), 32'd3);
      drain("fill_drain");
      for (int k = 1; k <= 5; k++)
         expect_log($sformatf("fill_log%0d", k), {8'(k), 8'(8'h30 + k)});

      // Forwarding: youngest match wins, miss goes to memory
      store(8'h20, 8'h11, 1'b0);
      store(8'h20, 8'h22, 1'b0);
      bus.cpu_addr  = 8'h20;
      bus.mem_rdata = 8'h7E;
      #1;
      check_value("fwd_hit",   32'(bus.cpu_rdata), 32'h0022);
      check_value("fwd_raddr", 32'(bus.mem_raddr), 32'h20);
      bus.cpu_addr = 8'h21;
      #1;
      check_value("fwd_miss", 32'(bus.cpu_rdata), 32'h007E);
      bus.cpu_addr   = 8'h20;
      bus.mem_wready = 1'b1;
      step();
      check_value("fwd_head_xfer", 32'(bus.cpu_rdata), 32'h0022);
      step();
      check_value("fwd_empty", 32'(bus.cpu_rdata), 32'h007E);
      expect_log("nomerge_log1", 16'h2011);
      expect_log("nomerge_log2", 16'h2022);

      // Simultaneous enqueue and transfer
      store(8'h40, 8'h01, 1'b0);
      store(8'h41, 8'h02, 1'b0);
      check_value("simul_pre", 32'(bus.sb_count), 32'd2);
      store(8'h42, 8'h03, 1'b1);
      check_value("simul_count", 32'(bus.sb_count), 32'd2);
      drain("simul_drain");
      expect_log("simul_log1", 16'h4001);
      expect_log("simul_log2", 16'h4102);
      expect_log("simul_log3", 16'h4203);

      // Wrap: 10 stores under an irregular ready pattern
      begin
         int i = 0;
         int cyc = 0;
         while (i < 10 && cyc < 200) begin
            bus.cpu_memwrite = 1'b1;
            bus.cpu_addr     = 8'(8'h80 + i);
            bus.cpu_wdata    = 8'(8'hC0 + i);
            bus.mem_wready   = rdy_pat[cyc % 16];
            #1;
            if (!bus.stall) i++;
            step();
            cyc++;
         end
         check_value("wrap_issued", i, 10);
      end
      drain("wrap_drain");
      for (int k = 0; k < 10; k++)
         expect_log($sformatf("wrap_log%0d", k), {8'(8'h80 + k), 8'(8'hC0 + k)});
      check_value("wrap_total", log_q.size(), log_rd);

      // Reset in the middle of a held drain
      store(8'h50, 8'h0A, 1'b0);
      store(8'h51, 8'h0B, 1'b0);
      store(8'h52, 8'h0C, 1'b0);
      check_value("rst_pre_count",  32'(bus.sb_count),   32'd3);
      check_value("rst_pre_wvalid", 32'(bus.mem_wvalid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_value("rst_mid_wvalid", 32'(bus.mem_wvalid), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check_value("rst_post_count",  32'(bus.sb_count),   32'd0);
      check_value("rst_post_wvalid", 32'(bus.mem_wvalid), 32'd0);
      check_value("rst_no_xfer",     log_q.size(),        log_rd);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", vectors, 0);
      $fatal(1, "timeout");
   end
endmodule
